// File: rtl/int_vector_seq_pkg.sv
// int_vector_seq_pkg: state, kind and vector encodings shared by the interrupt sequencer
package int_vector_seq_pkg;
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_RST_WAIT = 4'd1;
    localparam logic [3:0] S_PUSH_H   = 4'd2;
    localparam logic [3:0] S_PUSH_L   = 4'd3;
    localparam logic [3:0] S_PUSH_P   = 4'd4;
    localparam logic [3:0] S_VEC_SET  = 4'd5;
    localparam logic [3:0] S_FETCH_LO = 4'd6;
    localparam logic [3:0] S_FETCH_HI = 4'd7;
    localparam logic [3:0] S_LOAD_PC  = 4'd8;
    typedef enum logic [1:0] {K_RES, K_NMI, K_IRQ, K_BRK} kind_e;
    localparam logic [7:0] VEC_RES = 8'hFC;
    localparam logic [7:0] VEC_IRQ = 8'hFE;
    localparam logic [7:0] VEC_NMI = 8'hFA;
    localparam logic [7:0] ADH_VEC = 8'hFF;
endpackage

// File: rtl/int_sync_edge.sv
// int_sync_edge: N-flop synchroniser for an async active-low pin plus a synchronised falling-edge pulse
module int_sync_edge #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_i,
    output logic sync_o,
    output logic fall_o
);
    logic [N-1:0] sync_q;
    logic         prev_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= (sync_q << 1) | N'(a_i);
            prev_q <= sync_o;
        end
    end
    assign sync_o = sync_q[N-1];
    assign fall_o = prev_q & ~sync_o;
endmodule

// File: rtl/int_vector_seq.sv
// int_vector_seq: arbitrates RESET/NMI/IRQ/BRK at instruction boundaries and runs push + vector fetch cycles
module int_vector_seq
    import int_vector_seq_pkg::*;
#(
    parameter int NMI_SYNC  = 2,
    parameter int RST_DUMMY = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic nmi_n,
    input  logic irq_n,
    input  logic iflag,
    input  logic instr_done,
    input  logic brk_req,
    output logic setreset,
    output logic setirq,
    output logic setnmi,
    output logic pc_inc,
    output logic adloa,
    output logic adh_ff,
    output logic push_pch,
    output logic push_pcl,
    output logic push_p,
    output logic b_bit,
    output logic vec_lo_ld,
    output logic vec_hi_ld,
    output logic pc_load,
    output logic set_iflag,
    output logic busy
);
    localparam int CW = RST_DUMMY > 1 ? $clog2(RST_DUMMY) : 1;

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    kind_e         kind_q, kind_d, kind_v;
    logic          b_q, b_d, pend_q, pend_d;
    logic          nmi_fall, irq_sync, irq_act, vec_st, nmi_commit;

    int_sync_edge #(.N(NMI_SYNC)) u_nmi (.clk(clk), .rst_n(rst_n), .a_i(nmi_n), .sync_o(), .fall_o(nmi_fall));
    int_sync_edge #(.N(NMI_SYNC)) u_irq (.clk(clk), .rst_n(rst_n), .a_i(irq_n), .sync_o(irq_sync), .fall_o());

    assign irq_act    = ~irq_sync & ~iflag;
    assign vec_st     = state_q == S_VEC_SET;
    // a pending NMI hijacks an IRQ/BRK sequence that has not yet chosen its vector
    assign kind_v     = (pend_q && (kind_q == K_IRQ || kind_q == K_BRK)) ? K_NMI : kind_q;
    assign nmi_commit = vec_st && kind_v == K_NMI;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        b_d     = b_q;
        pend_d  = nmi_fall | (pend_q & ~nmi_commit);
        case (state_q)
            S_IDLE: if (instr_done && (pend_q || brk_req || irq_act)) begin
                state_d = S_PUSH_H;
                kind_d  = pend_q ? K_NMI : brk_req ? K_BRK : K_IRQ;
                b_d     = ~pend_q & brk_req;
            end
            S_RST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(RST_DUMMY - 1)) begin
                    state_d = S_VEC_SET;
                    cnt_d   = '0;
                    kind_d  = K_RES;
                    b_d     = 1'b0;
                end
            end
            S_PUSH_H:   state_d = S_PUSH_L;
            S_PUSH_L:   state_d = S_PUSH_P;
            S_PUSH_P:   state_d = S_VEC_SET;
            S_VEC_SET: begin
                state_d = S_FETCH_LO;
                kind_d  = kind_v;
            end
            S_FETCH_LO: state_d = S_FETCH_HI;
            S_FETCH_HI: state_d = S_LOAD_PC;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST_WAIT;
            cnt_q   <= '0;
            kind_q  <= K_RES;
            b_q     <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
            b_q     <= b_d;
            pend_q  <= pend_d;
        end
    end

    assign busy      = state_q != S_IDLE;
    assign push_pch  = state_q == S_PUSH_H;
    assign push_pcl  = state_q == S_PUSH_L;
    assign push_p    = state_q == S_PUSH_P;
    assign b_bit     = b_q & (push_pch | push_pcl | push_p);
    assign setreset  = vec_st && kind_v == K_RES;
    assign setnmi    = nmi_commit;
    assign setirq    = vec_st && (kind_v == K_IRQ || kind_v == K_BRK);
    assign vec_lo_ld = state_q == S_FETCH_LO;
    assign vec_hi_ld = state_q == S_FETCH_HI;
    assign pc_inc    = vec_lo_ld;
    assign adloa     = vec_lo_ld | vec_hi_ld;
    assign adh_ff    = vec_lo_ld | vec_hi_ld;
    assign pc_load   = state_q == S_LOAD_PC;
    assign set_iflag = pc_load;
endmodule

// File: tb/tb_int_vector_seq.sv
// tb_int_vector_seq: table-driven per-cycle check of the sequencer outputs plus hijack, NMI-vs-IRQ and abort sequences
module tb_int_vector_seq;
    logic clk = 1'b0;
    logic rst_n, nmi_n, irq_n, iflag, instr_done, brk_req;
    logic setreset, setirq, setnmi, pc_inc, adloa, adh_ff, push_pch, push_pcl, push_p;
    logic b_bit, vec_lo_ld, vec_hi_ld, pc_load, set_iflag, busy;
    logic [14:0] act;
    int n_chk = 0;
    int n_fail = 0;

    localparam logic [14:0] BUSY = 15'd1 << 0;
    localparam logic [14:0] SIFL = 15'd1 << 1;
    localparam logic [14:0] PCLD = 15'd1 << 2;
    localparam logic [14:0] VHI  = 15'd1 << 3;
    localparam logic [14:0] VLO  = 15'd1 << 4;
    localparam logic [14:0] BB   = 15'd1 << 5;
    localparam logic [14:0] PP   = 15'd1 << 6;
    localparam logic [14:0] PL   = 15'd1 << 7;
    localparam logic [14:0] PH   = 15'd1 << 8;
    localparam logic [14:0] ADH  = 15'd1 << 9;
    localparam logic [14:0] ADLO = 15'd1 << 10;
    localparam logic [14:0] PCI  = 15'd1 << 11;
    localparam logic [14:0] SNMI = 15'd1 << 12;
    localparam logic [14:0] SIRQ = 15'd1 << 13;
    localparam logic [14:0] SRES = 15'd1 << 14;

    localparam logic [14:0] E_ID = 15'd0;
    localparam logic [14:0] E_RW = BUSY;
    localparam logic [14:0] E_PH = BUSY | PH;
    localparam logic [14:0] E_PL = BUSY | PL;
    localparam logic [14:0] E_PP = BUSY | PP;
    localparam logic [14:0] E_VR = BUSY | SRES;
    localparam logic [14:0] E_VI = BUSY | SIRQ;
    localparam logic [14:0] E_VN = BUSY | SNMI;
    localparam logic [14:0] E_FL = BUSY | ADLO | ADH | VLO | PCI;
    localparam logic [14:0] E_FH = BUSY | ADLO | ADH | VHI;
    localparam logic [14:0] E_LD = BUSY | PCLD | SIFL;

    typedef struct packed {
        logic        irq_n;
        logic        iflag;
        logic        done;
        logic        brk;
        logic [14:0] exp;
    } vec_t;
    vec_t tv[$];

    int_vector_seq #(.NMI_SYNC(2), .RST_DUMMY(3)) dut (
        .clk(clk), .rst_n(rst_n), .nmi_n(nmi_n), .irq_n(irq_n), .iflag(iflag),
        .instr_done(instr_done), .brk_req(brk_req), .setreset(setreset), .setirq(setirq),
        .setnmi(setnmi), .pc_inc(pc_inc), .adloa(adloa), .adh_ff(adh_ff), .push_pch(push_pch),
        .push_pcl(push_pcl), .push_p(push_p), .b_bit(b_bit), .vec_lo_ld(vec_lo_ld),
        .vec_hi_ld(vec_hi_ld), .pc_load(pc_load), .set_iflag(set_iflag), .busy(busy)
    );

    assign act = {setreset, setirq, setnmi, pc_inc, adloa, adh_ff, push_pch, push_pcl, push_p,
                  b_bit, vec_lo_ld, vec_hi_ld, pc_load, set_iflag, busy};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=%h required=finish", act);
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [14:0] e);
        n_chk++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, e);
        end
    endtask

    task automatic run(input string nm, input logic [14:0] e);
        chk(nm, e);
        cyc();
    endtask

    task automatic add(input logic i, input logic f, input logic d, input logic b, input logic [14:0] e);
        tv.push_back({i, f, d, b, e});
    endtask

    initial begin
        // rows: state observed after each clock, starting at the cycle reset is released
        add(1, 0, 0, 0, E_RW); add(1, 0, 0, 0, E_RW); add(1, 0, 0, 0, E_RW);
        add(1, 0, 0, 0, E_VR); add(1, 0, 0, 0, E_FL); add(1, 0, 0, 0, E_FH);
        add(1, 0, 0, 0, E_LD); add(0, 0, 0, 0, E_ID); add(0, 0, 0, 0, E_ID);
        add(0, 1, 1, 0, E_ID); add(0, 0, 0, 0, E_ID); add(0, 0, 1, 0, E_ID);
        add(0, 0, 0, 0, E_PH); add(0, 0, 1, 1, E_PL); add(0, 0, 0, 0, E_PP);
        add(0, 0, 0, 0, E_VI); add(0, 0, 0, 0, E_FL); add(0, 0, 0, 0, E_FH);
        add(0, 0, 0, 0, E_LD); add(1, 0, 0, 0, E_ID); add(1, 0, 0, 0, E_ID);
        add(1, 0, 1, 0, E_ID); add(1, 0, 0, 1, E_ID); add(1, 0, 1, 1, E_ID);
        add(1, 0, 0, 0, E_PH | BB); add(1, 0, 0, 0, E_PL | BB); add(1, 0, 0, 0, E_PP | BB);
        add(1, 0, 0, 0, E_VI); add(1, 0, 0, 0, E_FL); add(1, 0, 0, 0, E_FH);
        add(1, 0, 0, 0, E_LD); add(1, 0, 0, 0, E_ID);

        rst_n = 0; nmi_n = 1; irq_n = 1; iflag = 0; instr_done = 0; brk_req = 0;
        cyc();
        cyc();
        chk("reset", E_RW);
        rst_n = 1;
        for (int i = 0; i < tv.size(); i++) begin
            irq_n = tv[i].irq_n; iflag = tv[i].iflag; instr_done = tv[i].done; brk_req = tv[i].brk;
            chk($sformatf("row%0d", i), tv[i].exp);
            cyc();
        end
        irq_n = 1; iflag = 0; instr_done = 0; brk_req = 0;

        // hijack: NMI pin drops early enough that its synchronised edge is pending at VEC_SET
        brk_req = 1; instr_done = 1;
        run("hj_idle", E_ID);
        brk_req = 0; instr_done = 0;
        chk("hj_ph", E_PH | BB);
        nmi_n = 0;
        cyc();
        run("hj_pl", E_PL | BB);
        run("hj_pp", E_PP | BB);
        run("hj_vec", E_VN);
        run("hj_fl", E_FL);
        run("hj_fh", E_FH);
        chk("hj_ld", E_LD);
        nmi_n = 1;
        cyc();
        instr_done = 1;
        run("hj_idle2", E_ID);
        instr_done = 0;
        run("hj_pend_clr", E_ID);

        // NMI and IRQ both present at one boundary
        nmi_n = 0; irq_n = 0;
        for (int i = 0; i < 4; i++) run("nv_wait", E_ID);
        instr_done = 1;
        run("nv_idle", E_ID);
        instr_done = 0;
        run("nv_ph", E_PH);
        run("nv_pl", E_PL);
        run("nv_pp", E_PP);
        run("nv_vec", E_VN);
        run("nv_fl", E_FL);
        run("nv_fh", E_FH);
        run("nv_ld", E_LD);
        nmi_n = 1;
        instr_done = 1;
        run("nv_idle2", E_ID);
        instr_done = 0;
        run("nv_ph2", E_PH);
        run("nv_pl2", E_PL);
        run("nv_pp2", E_PP);
        run("nv_irq", E_VI);
        run("nv_fl2", E_FL);
        run("nv_fh2", E_FH);
        run("nv_ld2", E_LD);
        irq_n = 1;
        run("nv_end", E_ID);

        // abort: reset asserted in FETCH_HI
        brk_req = 1; instr_done = 1;
        run("ab_idle", E_ID);
        brk_req = 0; instr_done = 0;
        run("ab_ph", E_PH | BB);
        run("ab_pl", E_PL | BB);
        run("ab_pp", E_PP | BB);
        run("ab_vec", E_VI);
        run("ab_fl", E_FL);
        chk("ab_fh", E_FH);
        #2 rst_n = 0;
        #1 chk("ab_async", E_RW);
        cyc();
        chk("ab_hold", E_RW);
        rst_n = 1;
        run("ab_rw0", E_RW);
        run("ab_rw1", E_RW);
        run("ab_rw2", E_RW);
        run("ab_vr", E_VR);
        run("ab_fl2", E_FL);
        run("ab_fh2", E_FH);
        run("ab_ld", E_LD);
        chk("ab_done", E_ID);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
